// File: rtl/iomem_initiator_if.sv
// Bundle of the command, response and iomem bus signals of iomem_initiator.
// master: the initiator side; slave: the environment (command source,
// response sink and iomem responder).
interface iomem_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           iomem_ready, iomem_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy,
           iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           iomem_ready, iomem_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy,
           iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
  );
endinterface

// File: rtl/iomem_initiator.sv
// iomem_initiator: bus-master end of the PicoSoC iomem peripheral interface.
// Commands are queued in a small FIFO and issued one at a time as iomem
// transactions; exactly one response is returned per command, in order.
// Optional feature macro TIMEOUT_EN: abort a transaction whose responder has
// not answered within TIMEOUT_CYCLES cycles and report rsp_error=1.
module iomem_initiator #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  iomem_initiator_if.master bus
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 32 + 32 + 4;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t           state;
  logic [ENT_W-1:0] fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  // A full FIFO refuses commands even if the FSM pops in the same cycle.
  assign bus.cmd_ready = (count != CNT_W'(CMD_DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == IDLE) && (count != '0);
  assign head          = fifo_mem[rd_ptr];
  assign bus.busy      = (count != '0) || (state != IDLE);

`ifdef TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        rsp_error_q;
  assign bus.rsp_error = rsp_error_q;
`else
  assign bus.rsp_error = 1'b0;
`endif

  // Command storage; contents need no reset, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.cmd_addr, bus.cmd_wdata, bus.cmd_wstrb};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Transaction FSM: issue one command, wait for the responder, hold the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      bus.iomem_valid <= 1'b0;
      bus.iomem_addr  <= '0;
      bus.iomem_wdata <= '0;
      bus.iomem_wstrb <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
`ifdef TIMEOUT_EN
      tmo_cnt         <= '0;
      rsp_error_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {bus.iomem_addr, bus.iomem_wdata, bus.iomem_wstrb} <= head;
            bus.iomem_valid <= 1'b1;
            state           <= REQ;
`ifdef TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
          end
        end
        REQ: begin
          // Dropping valid on the ready edge makes a one-cycle pulse complete
          // exactly one transaction; ready also wins over a same-cycle timeout.
          if (bus.iomem_ready) begin
            bus.iomem_valid <= 1'b0;
            bus.rsp_rdata   <= (bus.iomem_wstrb == 4'b0000) ? bus.iomem_rdata : '0;
            bus.rsp_valid   <= 1'b1;
            state           <= RSP;
`ifdef TIMEOUT_EN
            rsp_error_q     <= 1'b0;
          end else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            bus.iomem_valid <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_valid   <= 1'b1;
            rsp_error_q     <= 1'b1;
            state           <= RSP;
          end else begin
            tmo_cnt         <= tmo_cnt + 16'd1;
`endif
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_initiator.sv
// Bench for iomem_initiator: directed scenarios plus a randomized phase,
// checked against a queue-based model of commands and expected responses.
module tb_iomem_initiator;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } cmd_t;

  typedef struct packed {
    logic [31:0] r;
    logic        e;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;

  iomem_initiator_if bus ();

  iomem_initiator #(.CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  cmd_t cmd_q [$];
  rsp_t exp_q [$];

  int checks = 0;
  int errors = 0;

  bit          stall       = 1'b0;
  bit          rsp_rand    = 1'b0;
  bit          rsp_hold    = 1'b0;
  bit          force_en    = 1'b0;
  bit          late_pulse  = 1'b0;
  bit          expect_drop = 1'b0;
  logic [31:0] force_rdata = '0;
  int          fixed_lat   = 0;
  int          lat         = 0;
  int          wait_cnt    = 0;
  int          vc          = 0;
  int          vcycles     = 0;
  int          acc         = 0;
  int          done        = 0;
  int          n_rsp       = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got expired/unexpected, expected completion", nm);
  endtask

  // Response sink: rsp_ready is either held at rsp_hold or randomized.
  always @(posedge clk) begin
    #2;
    bus.rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : rsp_hold;
  end

  // Responder model: serves iomem transactions with a chosen latency, checks
  // the issued command against the queue and records the expected response.
  always @(posedge clk) begin
    logic [31:0] rd;
    #1;
    if (reset) begin
      bus.iomem_ready = 1'b0;
      bus.iomem_rdata = '0;
      wait_cnt        = 0;
      vc              = 0;
      expect_drop     = 1'b0;
    end else begin
      if (expect_drop) begin
        chk("valid_drop", 32'(bus.iomem_valid), 32'd0);
        expect_drop = 1'b0;
      end
      if (bus.iomem_ready) begin
        bus.iomem_ready = 1'b0;
      end else if (late_pulse && !bus.iomem_valid) begin
        bus.iomem_ready = 1'b1;
        bus.iomem_rdata = 32'hDEADBEEF;
        late_pulse      = 1'b0;
      end else if (bus.iomem_valid) begin
        vc++;
        vcycles++;
        if (vc == 1) begin
          lat      = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
          wait_cnt = 0;
        end
        if (cmd_q.size() == 0) begin
          fail("unexpected_iomem_valid");
        end else begin
          chk("iomem_addr",  bus.iomem_addr,         cmd_q[0].a);
          chk("iomem_wdata", bus.iomem_wdata,        cmd_q[0].d);
          chk("iomem_wstrb", 32'(bus.iomem_wstrb),   32'(cmd_q[0].s));
          if (!stall && wait_cnt >= lat) begin
            rd = force_en ? force_rdata : $urandom;
            bus.iomem_ready = 1'b1;
            bus.iomem_rdata = rd;
            exp_q.push_back('{r: (cmd_q[0].s == 4'd0) ? rd : 32'd0, e: 1'b0});
            void'(cmd_q.pop_front());
            vc          = 0;
            expect_drop = 1'b1;
`ifdef TIMEOUT_EN
          end else if (vc == TMO) begin
            exp_q.push_back('{r: 32'd0, e: 1'b1});
            void'(cmd_q.pop_front());
            vc          = 0;
            expect_drop = 1'b1;
`endif
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // Compare process: busy against outstanding work, responses against the model.
  always @(negedge clk) begin
    if (reset) begin
      acc  = 0;
      done = 0;
    end else begin
      chk("busy", 32'(bus.busy), 32'(acc != done));
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail("spurious_rsp_valid");
        end else if (bus.rsp_ready) begin
          chk("rsp_rdata", bus.rsp_rdata,        exp_q[0].r);
          chk("rsp_error", 32'(bus.rsp_error),   32'(exp_q[0].e));
          void'(exp_q.pop_front());
          done++;
          n_rsp++;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) acc++;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_wstrb = s;
    bus.cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        cmd_q.push_back('{a: a, d: d, s: s});
        break;
      end
      n++;
      if (n > 200) begin
        fail("send_bound");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm);
    int n = 0;
    while (!bus.rsp_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.rsp_valid) fail(nm);
  endtask

  task automatic consume();
    int n = 0;
    rsp_hold = 1'b1;
    while (bus.rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.rsp_valid) fail("consume_bound");
    rsp_hold = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((bus.busy || exp_q.size() != 0 || cmd_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.busy) fail(nm);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit, expected $finish");
    $fatal(1);
  end

  initial begin
    int v0;
    int r0;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready",   32'(bus.cmd_ready),   32'd1);
    chk("reset_iomem_valid", 32'(bus.iomem_valid), 32'd0);
    chk("reset_rsp_valid",   32'(bus.rsp_valid),   32'd0);
    chk("reset_busy",        32'(bus.busy),        32'd0);
    chk("reset_rsp_rdata",   bus.rsp_rdata,        32'd0);
    chk("reset_iomem_addr",  bus.iomem_addr,       32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Write to GPIO, responder answers in the first REQ cycle.
    fixed_lat = 0;
    v0 = vcycles;
    send(32'h03000000, 32'h000000A5, 4'hF);
    wait_rsp("t1_rsp_bound");
    chk("t1_rdata",        bus.rsp_rdata,         32'd0);
    chk("t1_error",        32'(bus.rsp_error),    32'd0);
    chk("t1_valid_cycles", 32'(vcycles - v0),     32'd1);
    chk("t1_valid_low",    32'(bus.iomem_valid),  32'd0);
    consume();

    // Read with the responder returning a known word after two wait cycles.
    fixed_lat   = 2;
    force_en    = 1'b1;
    force_rdata = 32'h12345678;
    v0 = vcycles;
    send(32'h03000000, 32'h0, 4'h0);
    wait_rsp("t2_rsp_bound");
    chk("t2_rdata",        bus.rsp_rdata,         32'h12345678);
    chk("t2_valid_cycles", 32'(vcycles - v0),     32'd3);
    consume();
    force_en = 1'b0;

    // Fill: one in flight plus DEPTH queued, then release everything.
    stall = 1'b1;
    r0 = n_rsp;
    for (int i = 0; i < DEPTH + 1; i++) begin
      send(32'h04000000 + 32'(4 * i), $urandom, (i % 2 == 0) ? 4'h0 : 4'h3);
    end
    chk("t3_cmd_ready_full", 32'(bus.cmd_ready),   32'd0);
    chk("t3_iomem_valid",    32'(bus.iomem_valid), 32'd1);
    stall     = 1'b0;
    fixed_lat = -1;
    rsp_hold  = 1'b1;
    wait_idle("t3_drain_bound");
    rsp_hold = 1'b0;
    chk("t3_rsp_count", 32'(n_rsp - r0), 32'd5);
    chk("t3_busy_end",  32'(bus.busy),   32'd0);

    // Asynchronous reset in the middle of a REQ.
    stall = 1'b1;
    send(32'h03000010, 32'h1, 4'hF);
    begin
      int n = 0;
      while (!bus.iomem_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (!bus.iomem_valid) fail("t4_valid_bound");
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t4_iomem_valid", 32'(bus.iomem_valid), 32'd0);
    chk("t4_cmd_ready",   32'(bus.cmd_ready),   32'd1);
    chk("t4_busy",        32'(bus.busy),        32'd0);
    chk("t4_rsp_valid",   32'(bus.rsp_valid),   32'd0);
    cmd_q.delete();
    exp_q.delete();
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    r0 = n_rsp;
    repeat (6) @(posedge clk);
    #1;
    chk("t4_no_rsp",       32'(n_rsp - r0),     32'd0);
    chk("t4_rsp_valid_lo", 32'(bus.rsp_valid),  32'd0);
    fixed_lat   = 1;
    force_en    = 1'b1;
    force_rdata = 32'h0BADF00D;
    send(32'h04000000, 32'h0, 4'h0);
    wait_rsp("t4_after_bound");
    chk("t4_after_rdata", bus.rsp_rdata, 32'h0BADF00D);
    consume();
    force_en = 1'b0;

`ifdef TIMEOUT_EN
    // Responder never answers: timeout after TMO valid cycles; late ready ignored.
    stall = 1'b1;
    v0 = vcycles;
    send(32'h03000020, 32'h0, 4'h0);
    wait_rsp("t5_rsp_bound");
    chk("t5_valid_cycles", 32'(vcycles - v0),  32'd8);
    chk("t5_error",        32'(bus.rsp_error), 32'd1);
    chk("t5_rdata",        bus.rsp_rdata,      32'd0);
    late_pulse = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_late_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t5_late_error",     32'(bus.rsp_error), 32'd1);
    stall = 1'b0;
    consume();
    chk("t5_busy_end", 32'(bus.busy), 32'd0);

    // Ready in exactly the last allowed REQ cycle wins over the timeout.
    fixed_lat   = TMO - 1;
    force_en    = 1'b1;
    force_rdata = 32'hCAFEF00D;
    v0 = vcycles;
    send(32'h03000024, 32'h0, 4'h0);
    wait_rsp("t6_rsp_bound");
    chk("t6_error",        32'(bus.rsp_error), 32'd0);
    chk("t6_rdata",        bus.rsp_rdata,      32'hCAFEF00D);
    chk("t6_valid_cycles", 32'(vcycles - v0),  32'd8);
    consume();
    force_en = 1'b0;
`endif

    // Randomized traffic with random responder latency and response backpressure.
    fixed_lat = -1;
    rsp_rand  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      logic [3:0]  s;
      a = (($urandom_range(0, 1) == 0) ? 32'h03000000 : 32'h04000000) | ($urandom & 32'h00FFFFFC);
      s = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      send(a, $urandom, s);
    end
    wait_idle("rand_drain_bound");
    rsp_rand = 1'b0;
    chk("rand_cmd_q_empty", 32'(cmd_q.size()), 32'd0);
    chk("rand_exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_busy_end",    32'(bus.busy),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
